// File: rtl/compress_pkg.sv
// Shared definitions for the matching stage: word width, pattern codes and
// the encoded bit length that goes with each code.
package compress_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    CODE_ZZZZ = 3'd0,
    CODE_MMMM = 3'd1,
    CODE_ZZZX = 3'd2,
    CODE_MMMX = 3'd3,
    CODE_MMXX = 3'd4,
    CODE_XXXX = 3'd5
  } code_e;

  localparam int LEN_ZZZZ      = 2;
  localparam int LEN_MMMM_BASE = 2;
  localparam int LEN_ZZZX      = 12;
  localparam int LEN_MMMX_BASE = 12;
  localparam int LEN_MMXX_BASE = 20;
  localparam int LEN_XXXX      = 34;

  // Match codes also carry the slot index, so their length grows with idxW.
  function automatic logic [5:0] codeLength(input code_e code, input int idxW);
    logic [5:0] len;
    case (code)
      CODE_ZZZZ: len = 6'(LEN_ZZZZ);
      CODE_MMMM: len = 6'(LEN_MMMM_BASE + idxW);
      CODE_ZZZX: len = 6'(LEN_ZZZX);
      CODE_MMMX: len = 6'(LEN_MMMX_BASE + idxW);
      CODE_MMXX: len = 6'(LEN_MMXX_BASE + idxW);
      default:   len = 6'(LEN_XXXX);
    endcase
    return len;
  endfunction

  function automatic logic isPushed(input code_e code);
    return (code != CODE_ZZZZ) && (code != CODE_MMMM);
  endfunction

endpackage

// File: rtl/word_matcher.sv
// Classifies one 32-bit word against the valid part of a dictionary view and
// picks the best-grade match, lowest slot first.
module word_matcher
  import compress_pkg::*;
#(
  parameter int DICT_ENTRY = 16,
  localparam int IDX_W = $clog2(DICT_ENTRY)
) (
  input  logic [WORD_W-1:0]                  word_i,
  input  logic [DICT_ENTRY-1:0][WORD_W-1:0]  dictWords_i,
  input  logic [IDX_W:0]                     dictCount_i,
  output code_e                              code_o,
  output logic [5:0]                         length_o,
  output logic [IDX_W-1:0]                   location_o
);

  logic             hitFull, hitHi24, hitHi16;
  logic [IDX_W-1:0] locFull, locHi24, locHi16;

  // Scanning downward leaves the lowest matching slot in each locator.
  always_comb begin
    hitFull = 1'b0;
    hitHi24 = 1'b0;
    hitHi16 = 1'b0;
    locFull = '0;
    locHi24 = '0;
    locHi16 = '0;
    for (int s = DICT_ENTRY - 1; s >= 0; s--) begin
      if ((IDX_W + 1)'(s) < dictCount_i) begin
        if (word_i == dictWords_i[s]) begin
          hitFull = 1'b1;
          locFull = IDX_W'(s);
        end
        if (word_i[31:8] == dictWords_i[s][31:8]) begin
          hitHi24 = 1'b1;
          locHi24 = IDX_W'(s);
        end
        if (word_i[31:16] == dictWords_i[s][31:16]) begin
          hitHi16 = 1'b1;
          locHi16 = IDX_W'(s);
        end
      end
    end
  end

  always_comb begin
    code_o     = CODE_XXXX;
    location_o = '0;
    if (word_i == '0) begin
      code_o = CODE_ZZZZ;
    end else if (hitFull) begin
      code_o     = CODE_MMMM;
      location_o = locFull;
    end else if (word_i[31:8] == '0) begin
      code_o = CODE_ZZZX;
    end else if (hitHi24) begin
      code_o     = CODE_MMMX;
      location_o = locHi24;
    end else if (hitHi16) begin
      code_o     = CODE_MMXX;
      location_o = locHi16;
    end
    length_o = codeLength(code_o, IDX_W);
  end

endmodule

// File: rtl/matching_stage_nw.sv
// FIFO-dictionary matching stage: classifies LANES words per beat, pushes the
// non-trivial ones into a circular dictionary, and registers the results.
module matching_stage_nw
  import compress_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DICT_ENTRY = 16,
  localparam int IDX_W = $clog2(DICT_ENTRY)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [LANES*WORD_W-1:0]  i_word,
  input  logic                     i_clear,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES*3-1:0]       o_code,
  output logic [LANES*6-1:0]       o_length,
  output logic [LANES*IDX_W-1:0]   o_location,
  output logic [IDX_W:0]           o_dict_count,
  output logic                     o_dict_full
);

  logic [DICT_ENTRY-1:0][WORD_W-1:0] dict_q;
  logic [IDX_W:0]                    count_q;
  logic [IDX_W-1:0]                  wptr_q;
  logic                              valid_q;
  logic [LANES*3-1:0]                code_q, code_d;
  logic [LANES*6-1:0]                length_q, length_d;
  logic [LANES*IDX_W-1:0]            location_q, location_d;
  logic                              accept;

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  // Each lane sees the dictionary as left by the pushes of the lanes before it.
  for (genvar k = 0; k < LANES; k++) begin : lane
    logic [DICT_ENTRY-1:0][WORD_W-1:0] viewIn, viewOut;
    logic [IDX_W-1:0]                  ptrIn, ptrOut;
    logic [IDX_W:0]                    cntIn, cntOut;
    logic [WORD_W-1:0]                 word;
    code_e                             code;
    logic [5:0]                        len;
    logic [IDX_W-1:0]                  loc;

    assign word = i_word[k*WORD_W +: WORD_W];

    if (k == 0) begin : gFirst
      assign viewIn = dict_q;
      assign ptrIn  = i_clear ? '0 : wptr_q;
      assign cntIn  = i_clear ? '0 : count_q;
    end else begin : gChained
      assign viewIn = lane[k-1].viewOut;
      assign ptrIn  = lane[k-1].ptrOut;
      assign cntIn  = lane[k-1].cntOut;
    end

    word_matcher #(.DICT_ENTRY(DICT_ENTRY)) uMatcher (
      .word_i      (word),
      .dictWords_i (viewIn),
      .dictCount_i (cntIn),
      .code_o      (code),
      .length_o    (len),
      .location_o  (loc)
    );

    always_comb begin
      viewOut = viewIn;
      ptrOut  = ptrIn;
      cntOut  = cntIn;
      if (isPushed(code)) begin
        viewOut[ptrIn] = word;
        ptrOut         = ptrIn + IDX_W'(1);
        if (cntIn != (IDX_W + 1)'(DICT_ENTRY)) cntOut = cntIn + (IDX_W + 1)'(1);
      end
    end

    assign code_d[k*3 +: 3]             = code;
    assign length_d[k*6 +: 6]           = len;
    assign location_d[k*IDX_W +: IDX_W] = loc;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      code_q     <= '0;
      length_q   <= '0;
      location_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      code_q     <= code_d;
      length_q   <= length_d;
      location_q <= location_d;
      count_q    <= lane[LANES-1].cntOut;
      wptr_q     <= lane[LANES-1].ptrOut;
    end else begin
      if (i_ready) valid_q <= 1'b0;
      if (i_clear) begin
        count_q <= '0;
        wptr_q  <= '0;
      end
    end
  end

  // Slot contents need no reset: validity comes entirely from count_q.
  always_ff @(posedge i_clk) begin
    if (accept) dict_q <= lane[LANES-1].viewOut;
  end

  assign o_valid      = valid_q;
  assign o_code       = code_q;
  assign o_length     = length_q;
  assign o_location   = location_q;
  assign o_dict_count = count_q;
  assign o_dict_full  = (count_q == (IDX_W + 1)'(DICT_ENTRY));

endmodule

// File: tb/tb_matching_stage_nw.sv
// Directed vector bench for matching_stage_nw with LANES=2, DICT_ENTRY=16.
module tb_matching_stage_nw;

  localparam int LANES = 2;
  localparam int DICT  = 16;
  localparam int IDX_W = 4;

  logic                   i_clk = 1'b0;
  logic                   i_reset;
  logic                   i_valid;
  logic                   o_ready;
  logic [LANES*32-1:0]    i_word;
  logic                   i_clear;
  logic                   o_valid;
  logic                   i_ready;
  logic [LANES*3-1:0]     o_code;
  logic [LANES*6-1:0]     o_length;
  logic [LANES*IDX_W-1:0] o_location;
  logic [IDX_W:0]         o_dict_count;
  logic                   o_dict_full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic        clr;
    logic [2:0]  c0;
    logic [5:0]  l0;
    logic [3:0]  p0;
    logic [2:0]  c1;
    logic [5:0]  l1;
    logic [3:0]  p1;
    logic        chkCnt;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[7];

  matching_stage_nw #(.LANES(LANES), .DICT_ENTRY(DICT)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_word       (i_word),
    .i_clear      (i_clear),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_code       (o_code),
    .o_length     (o_length),
    .o_location   (o_location),
    .o_dict_count (o_dict_count),
    .o_dict_full  (o_dict_full)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offers one beat, waits (bounded) for acceptance, and returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1, input logic clr);
    int n = 0;
    i_word  = {w1, w0};
    i_valid = 1'b1;
    i_clear = clr;
    while (!o_ready && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!o_ready) checkOutput("accept_timeout", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic checkLane(input string name, input int k, input logic [2:0] c,
                           input logic [5:0] l, input logic [3:0] p);
    checkOutput({name, "_code"}, 32'(o_code[k*3 +: 3]), 32'(c));
    checkOutput({name, "_len"},  32'(o_length[k*6 +: 6]), 32'(l));
    checkOutput({name, "_loc"},  32'(o_location[k*IDX_W +: IDX_W]), 32'(p));
  endtask

  initial begin
    vecs[0] = '{32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 3'd5, 6'd34, 4'd0, 3'd1, 6'd6,  4'd0, 1'b1, 5'd1};
    vecs[1] = '{32'h00000000, 32'h000000A5, 1'b0, 3'd0, 6'd2,  4'd0, 3'd2, 6'd12, 4'd0, 1'b0, 5'd0};
    vecs[2] = '{32'hAABBCC11, 32'hAABB1234, 1'b0, 3'd3, 6'd16, 4'd0, 3'd4, 6'd24, 4'd0, 1'b0, 5'd0};
    vecs[3] = '{32'hCAFE1234, 32'hCAFE0000, 1'b1, 3'd5, 6'd34, 4'd0, 3'd4, 6'd24, 4'd0, 1'b0, 5'd0};
    vecs[4] = '{32'hCAFE1234, 32'hCAFE12AB, 1'b0, 3'd1, 6'd6,  4'd0, 3'd3, 6'd16, 4'd0, 1'b0, 5'd0};
    vecs[5] = '{32'h000000A5, 32'h00000001, 1'b0, 3'd2, 6'd12, 4'd0, 3'd2, 6'd12, 4'd0, 1'b0, 5'd0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 3'd0, 6'd2,  4'd0, 3'd0, 6'd2,  4'd0, 1'b1, 5'd0};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_word  = '0;
    i_clear = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_count", 32'(o_dict_count), 32'd0);
    checkOutput("reset_full",  32'(o_dict_full), 32'd0);
    checkOutput("reset_ready", 32'(o_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].w0, vecs[v].w1, vecs[v].clr);
      checkOutput($sformatf("vec%0d_valid", v), 32'(o_valid), 32'd1);
      checkLane($sformatf("vec%0d_lane0", v), 0, vecs[v].c0, vecs[v].l0, vecs[v].p0);
      checkLane($sformatf("vec%0d_lane1", v), 1, vecs[v].c1, vecs[v].l1, vecs[v].p1);
      if (vecs[v].chkCnt) checkOutput($sformatf("vec%0d_count", v), 32'(o_dict_count), 32'(vecs[v].cnt));
    end

    @(posedge i_clk);
    #1;
    checkOutput("drain_valid", 32'(o_valid), 32'd0);

    // Backpressure: A is accepted, B waits while i_ready is low.
    i_ready = 1'b0;
    applyStimulus(32'hDEADBEEF, 32'h00000000, 1'b0);
    checkOutput("stall_valid", 32'(o_valid), 32'd1);
    i_word  = {32'hDEAD0000, 32'hDEADBEEF};
    i_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge i_clk);
      #1;
      checkOutput($sformatf("stall%0d_ready", c), 32'(o_ready), 32'd0);
      checkLane($sformatf("stall%0d_lane0", c), 0, 3'd5, 6'd34, 4'd0);
      checkLane($sformatf("stall%0d_lane1", c), 1, 3'd0, 6'd2, 4'd0);
      checkOutput($sformatf("stall%0d_count", c), 32'(o_dict_count), 32'd1);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    checkOutput("release_valid", 32'(o_valid), 32'd1);
    checkLane("release_lane0", 0, 3'd1, 6'd6, 4'd0);
    checkLane("release_lane1", 1, 3'd4, 6'd24, 4'd0);
    @(posedge i_clk);
    #1;
    checkOutput("release_drain", 32'(o_valid), 32'd0);

    // Asynchronous reset while a result is pending.
    i_ready = 1'b0;
    applyStimulus(32'h11111111, 32'h22222222, 1'b0);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("midreset_valid", 32'(o_valid), 32'd0);
    checkOutput("midreset_count", 32'(o_dict_count), 32'd0);
    checkOutput("midreset_code",  32'(o_code), 32'd0);
    checkOutput("midreset_len",   32'(o_length), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_ready = 1'b1;

    // Fill all 16 slots, then wrap onto slot 0.
    for (int b = 0; b < 8; b++) begin
      applyStimulus({8'(2*b + 1), 24'h5A5A5A}, {8'(2*b + 2), 24'h5A5A5A}, 1'b0);
      checkOutput($sformatf("fill%0d_code0", b), 32'(o_code[2:0]), 32'd5);
      checkOutput($sformatf("fill%0d_code1", b), 32'(o_code[5:3]), 32'd5);
      checkOutput($sformatf("fill%0d_count", b), 32'(o_dict_count), 32'(2*b + 2));
    end
    checkOutput("fill_full", 32'(o_dict_full), 32'd1);
    applyStimulus(32'h12345678, 32'h00000000, 1'b0);
    checkLane("wrap_lane0", 0, 3'd5, 6'd34, 4'd0);
    checkOutput("wrap_full",  32'(o_dict_full), 32'd1);
    checkOutput("wrap_count", 32'(o_dict_count), 32'd16);
    applyStimulus(32'h123456FF, 32'h00000000, 1'b0);
    checkLane("wrap_match", 0, 3'd3, 6'd16, 4'd0);
    applyStimulus(32'h015A5A5A, 32'h00000000, 1'b0);
    checkLane("wrap_evicted", 0, 3'd5, 6'd34, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
